// File: rtl/pll_ctrl_pkg.sv
// Shared state encoding and default timing constants for the PLL lock controller.
// The state encoding is exported on state_o, so it is fixed explicitly here.
package pll_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_OFF       = 3'd0,
      ST_RESET     = 3'd1,
      ST_WAIT_LOCK = 3'd2,
      ST_STABLE    = 3'd3,
      ST_READY     = 3'd4,
      ST_FAULT     = 3'd5
   } pll_state_e;

   localparam int DEF_RST_CYCLES    = 16;
   localparam int DEF_LOCK_TIMEOUT  = 1000;
   localparam int DEF_STABLE_CYCLES = 64;
   localparam int DEF_MAX_RETRIES   = 3;

   // The PLL is held in reset whenever it is not actively trying to lock or locked.
   function automatic logic pll_rst_for(input pll_state_e s);
      return (s == ST_OFF) || (s == ST_RESET) || (s == ST_FAULT);
   endfunction

endpackage

// File: rtl/pll_lock_ctrl_bit_sync.sv
// Two-flop synchronizer bringing one asynchronous bit into the refclk domain.
module bit_sync (
   input  logic refclk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL bring-up sequencer: pulses the PLL reset, qualifies lock over a stability
// window, retries on timeout up to a budget, and reports ready / fault / lock loss.
module pll_lock_ctrl
   import pll_ctrl_pkg::*;
#(
   parameter int RST_CYCLES    = DEF_RST_CYCLES,
   parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
   input  logic                             refclk,
   input  logic                             rst_n,
   input  logic                             enable,
   input  logic                             restart,
   input  logic                             pll_locked,
   output logic                             pll_rst,
   output logic                             ready,
   output logic                             fault,
   output logic                             lock_lost,
   output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt,
   output logic [2:0]                       state_o
);

   localparam int RW = $clog2(MAX_RETRIES + 1);
   localparam int CW = $clog2(RST_CYCLES + 1);
   localparam int TW = $clog2(LOCK_TIMEOUT + 1);
   localparam int SW = $clog2(STABLE_CYCLES + 1);

   localparam logic [RW-1:0] MAX_RETRIES_V = RW'(MAX_RETRIES);
   localparam logic [CW-1:0] RST_CYCLES_V  = CW'(RST_CYCLES);
   localparam logic [TW-1:0] TIMEOUT_V     = TW'(LOCK_TIMEOUT);
   localparam logic [SW-1:0] STABLE_V      = SW'(STABLE_CYCLES);

   pll_state_e    state;
   pll_state_e    state_nxt;
   logic          locked_s;
   logic [CW-1:0] rst_cnt;
   logic [CW-1:0] rst_inc;
   logic [TW-1:0] timer;
   logic [TW-1:0] timer_inc;
   logic [SW-1:0] stab_cnt;
   logic [SW-1:0] stab_inc;
   logic          timing_state;
   logic          timeout;
   logic          enter_reset;
   logic          clr_retry;
   logic          inc_retry;
   logic          lost_evt;

   bit_sync u_lock_sync (
      .refclk (refclk),
      .rst_n  (rst_n),
      .d      (pll_locked),
      .q      (locked_s)
   );

   // Saturating increments; each "inc" value counts the current cycle as well.
   assign rst_inc   = (rst_cnt == '1)  ? rst_cnt  : rst_cnt  + CW'(1);
   assign timer_inc = (timer == '1)    ? timer    : timer    + TW'(1);
   assign stab_inc  = (stab_cnt == '1) ? stab_cnt : stab_cnt + SW'(1);

   // The lock timer keeps running across STABLE<->WAIT_LOCK bounces.
   assign timing_state = (state == ST_WAIT_LOCK) || (state == ST_STABLE);
   assign timeout      = timing_state && (timer_inc >= TIMEOUT_V);

   always_comb begin
      state_nxt   = state;
      enter_reset = 1'b0;
      clr_retry   = 1'b0;
      inc_retry   = 1'b0;
      lost_evt    = 1'b0;
      if (!enable) begin
         state_nxt = ST_OFF;
      end else if (restart && (state != ST_OFF)) begin
         state_nxt   = ST_RESET;
         enter_reset = 1'b1;
         clr_retry   = 1'b1;
      end else begin
         case (state)
            ST_OFF: begin
               state_nxt   = ST_RESET;
               enter_reset = 1'b1;
               clr_retry   = 1'b1;
            end
            ST_RESET: begin
               if (rst_inc >= RST_CYCLES_V) state_nxt = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK, ST_STABLE: begin
               // Timeout outranks any lock event seen in the same cycle.
               if (timeout) begin
                  if (retry_cnt < MAX_RETRIES_V) begin
                     state_nxt   = ST_RESET;
                     enter_reset = 1'b1;
                     inc_retry   = 1'b1;
                  end else begin
                     state_nxt = ST_FAULT;
                  end
               end else if (state == ST_WAIT_LOCK) begin
                  if (locked_s) state_nxt = ST_STABLE;
               end else if (!locked_s) begin
                  state_nxt = ST_WAIT_LOCK;
               end else if (stab_inc >= STABLE_V) begin
                  state_nxt = ST_READY;
               end
            end
            ST_READY: begin
               if (!locked_s) begin
                  state_nxt   = ST_RESET;
                  enter_reset = 1'b1;
                  clr_retry   = 1'b1;
                  lost_evt    = 1'b1;
               end
            end
            ST_FAULT: state_nxt = ST_FAULT;
            default:  state_nxt = ST_OFF;
         endcase
      end
   end

   // Outputs are registered from the next state so they always match state_o.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_OFF;
         pll_rst   <= 1'b1;
         ready     <= 1'b0;
         fault     <= 1'b0;
         lock_lost <= 1'b0;
         retry_cnt <= '0;
         rst_cnt   <= '0;
         timer     <= '0;
         stab_cnt  <= '0;
      end else begin
         state     <= state_nxt;
         pll_rst   <= pll_rst_for(state_nxt);
         ready     <= (state_nxt == ST_READY);
         fault     <= (state_nxt == ST_FAULT);
         lock_lost <= lost_evt;
         if (clr_retry) begin
            retry_cnt <= '0;
         end else if (inc_retry) begin
            retry_cnt <= retry_cnt + RW'(1);
         end
         rst_cnt  <= ((state_nxt == ST_RESET) && !enter_reset) ? rst_inc : '0;
         timer    <= (timing_state && ((state_nxt == ST_WAIT_LOCK) || (state_nxt == ST_STABLE)))
                     ? timer_inc : '0;
         stab_cnt <= ((state == ST_STABLE) && (state_nxt == ST_STABLE)) ? stab_inc : '0;
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Scoreboard bench for pll_lock_ctrl: bring-up, timeouts to fault, lock loss,
// chattering lock, enable/restart priority and asynchronous reset.
module tb_pll_lock_ctrl;

   localparam int TB_RST  = 16;
   localparam int TB_TO   = 1000;
   localparam int TB_STB  = 64;
   localparam int TB_MAXR = 3;

   localparam logic [2:0] S_OFF       = 3'd0;
   localparam logic [2:0] S_RESET     = 3'd1;
   localparam logic [2:0] S_WAIT_LOCK = 3'd2;
   localparam logic [2:0] S_STABLE    = 3'd3;
   localparam logic [2:0] S_FAULT     = 3'd5;

   logic       refclk;
   logic       rst_n;
   logic       enable;
   logic       restart;
   logic       pll_locked;
   logic       pll_rst;
   logic       ready;
   logic       fault;
   logic       lock_lost;
   logic [1:0] retry_cnt;
   logic [2:0] state_o;

   int total = 0;
   int bad   = 0;
   int sb_q[$];

   pll_lock_ctrl #(
      .RST_CYCLES    (TB_RST),
      .LOCK_TIMEOUT  (TB_TO),
      .STABLE_CYCLES (TB_STB),
      .MAX_RETRIES   (TB_MAXR)
   ) dut (
      .refclk     (refclk),
      .rst_n      (rst_n),
      .enable     (enable),
      .restart    (restart),
      .pll_locked (pll_locked),
      .pll_rst    (pll_rst),
      .ready      (ready),
      .fault      (fault),
      .lock_lost  (lock_lost),
      .retry_cnt  (retry_cnt),
      .state_o    (state_o)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic score_check(input string tag, input logic [31:0] observed);
      if (sb_q.size() == 0) checkOutput({tag, "_noexp"}, observed, 32'hFFFF_FFFF);
      else checkOutput(tag, observed, sb_q.pop_front());
   endtask

   task automatic applyStimulus(input logic en, input logic rs, input logic lk);
      enable     = en;
      restart    = rs;
      pll_locked = lk;
   endtask

   task automatic step();
      @(negedge refclk);
   endtask

   task automatic wait_state(input string tag, input logic [2:0] s, input int limit);
      int n = 0;
      while (state_o !== s && n < limit) begin
         n++;
         step();
      end
      if (state_o !== s) checkOutput(tag, state_o, s);
   endtask

   task automatic measure_reset(output int n);
      n = 0;
      while (state_o === S_RESET && n < 64) begin
         n++;
         step();
      end
   endtask

   task automatic measure_low(output int n);
      n = 0;
      while (pll_rst === 1'b0 && n < 1100) begin
         n++;
         step();
      end
   endtask

   task automatic measure_ready(output int n);
      n = 0;
      while (ready !== 1'b1 && n < 300) begin
         n++;
         step();
      end
   endtask

   task automatic measure_lost(output int n);
      n = 0;
      while (lock_lost !== 1'b1 && n < 10) begin
         n++;
         step();
      end
   endtask

   initial begin
      int n;
      int width;
      logic saw;

      // Reset values while rst_n is held low.
      applyStimulus(1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      repeat (3) step();
      checkOutput("rst_state", state_o, S_OFF);
      checkOutput("rst_pll_rst", pll_rst, 1);
      checkOutput("rst_ready", ready, 0);
      checkOutput("rst_fault", fault, 0);
      checkOutput("rst_lock_lost", lock_lost, 0);
      checkOutput("rst_retry", retry_cnt, 0);
      rst_n = 1'b1;
      repeat (2) step();
      applyStimulus(1'b0, 1'b1, 1'b0);
      step();
      applyStimulus(1'b0, 1'b0, 1'b0);
      step();
      checkOutput("restart_in_off", state_o, S_OFF);

      // Normal bring-up: lock rises 100 cycles after pll_rst release.
      applyStimulus(1'b1, 1'b0, 1'b0);
      sb_q.push_back(TB_RST);
      step();
      checkOutput("s1_enter_reset", state_o, S_RESET);
      measure_reset(n);
      score_check("s1_rst_len", n);
      checkOutput("s1_wait_lock", state_o, S_WAIT_LOCK);
      checkOutput("s1_rst_low", pll_rst, 0);
      repeat (100) step();
      applyStimulus(1'b1, 1'b0, 1'b1);
      sb_q.push_back(2 + 1 + TB_STB);
      measure_ready(n);
      score_check("s1_ready_lat", n);
      checkOutput("s1_retry", retry_cnt, 0);
      checkOutput("s1_pll_rst", pll_rst, 0);

      // Lock loss while ready.
      applyStimulus(1'b1, 1'b0, 1'b0);
      sb_q.push_back(3);
      sb_q.push_back(1);
      sb_q.push_back(TB_RST);
      measure_lost(n);
      score_check("lost_lat", n);
      checkOutput("lost_ready", ready, 0);
      checkOutput("lost_pll_rst", pll_rst, 1);
      checkOutput("lost_retry", retry_cnt, 0);
      width = 0;
      n = 0;
      while (state_o === S_RESET && n < 64) begin
         width += int'(lock_lost);
         n++;
         step();
      end
      score_check("lost_width", width);
      score_check("lost_rst_len", n);

      // Lock never arrives: every attempt times out until the budget is spent.
      for (int a = 0; a <= TB_MAXR; a++) begin
         if (a > 0) begin
            sb_q.push_back(TB_RST);
            measure_reset(n);
            score_check("to_rst_len", n);
         end
         sb_q.push_back(a);
         score_check("to_retry", retry_cnt);
         sb_q.push_back(TB_TO);
         measure_low(n);
         score_check("to_low_len", n);
      end
      checkOutput("fault_state", state_o, S_FAULT);
      checkOutput("fault_flag", fault, 1);
      checkOutput("fault_pll_rst", pll_rst, 1);
      checkOutput("fault_retry", retry_cnt, TB_MAXR);
      repeat (20) step();
      checkOutput("fault_hold", fault, 1);
      applyStimulus(1'b1, 1'b1, 1'b0);
      step();
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("restart_state", state_o, S_RESET);
      checkOutput("restart_fault", fault, 0);
      checkOutput("restart_retry", retry_cnt, 0);
      checkOutput("restart_pll_rst", pll_rst, 1);

      // Chattering lock: 30 high / 5 low never qualifies and still times out.
      sb_q.push_back(TB_RST);
      measure_reset(n);
      score_check("chat_rst_len", n);
      sb_q.push_back(TB_TO);
      n = 0;
      saw = 1'b0;
      while (pll_rst === 1'b0 && n < 1100) begin
         applyStimulus(1'b1, 1'b0, (n % 35) < 30);
         saw = saw | ready;
         n++;
         step();
      end
      applyStimulus(1'b1, 1'b0, 1'b0);
      score_check("chat_low_len", n);
      checkOutput("chat_never_ready", saw, 0);
      checkOutput("chat_retry", retry_cnt, 1);

      // Bring-up with one retry used; lock loss then clears the budget.
      wait_state("wl2_reach", S_WAIT_LOCK, 64);
      applyStimulus(1'b1, 1'b0, 1'b1);
      sb_q.push_back(2 + 1 + TB_STB);
      measure_ready(n);
      score_check("s2_ready_lat", n);
      checkOutput("s2_retry_kept", retry_cnt, 1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      sb_q.push_back(3);
      measure_lost(n);
      score_check("lost2_lat", n);
      checkOutput("lost2_retry_clr", retry_cnt, 0);

      // enable=0 beats restart=1 while in STABLE.
      wait_state("wl3_reach", S_WAIT_LOCK, 64);
      applyStimulus(1'b1, 1'b0, 1'b1);
      wait_state("stable_reach", S_STABLE, 10);
      applyStimulus(1'b0, 1'b1, 1'b1);
      step();
      checkOutput("prio_state", state_o, S_OFF);
      checkOutput("prio_pll_rst", pll_rst, 1);
      checkOutput("prio_ready", ready, 0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      step();
      checkOutput("prio_stay_off", state_o, S_OFF);

      // Asynchronous reset in the middle of WAIT_LOCK.
      applyStimulus(1'b1, 1'b0, 1'b0);
      wait_state("wl4_reach", S_WAIT_LOCK, 64);
      repeat (5) step();
      checkOutput("arst_pre_low", pll_rst, 0);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("arst_state", state_o, S_OFF);
      checkOutput("arst_pll_rst", pll_rst, 1);
      checkOutput("arst_ready", ready, 0);
      checkOutput("arst_fault", fault, 0);
      checkOutput("arst_lock_lost", lock_lost, 0);
      checkOutput("arst_retry", retry_cnt, 0);
      step();
      rst_n = 1'b1;
      checkOutput("arst_held_off", state_o, S_OFF);
      step();
      checkOutput("arst_resequence", state_o, S_RESET);
      sb_q.push_back(TB_RST);
      measure_reset(n);
      score_check("arst_rst_len", n);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
